circuito_codificador_param: RTL and testbench
=============================================

// Module: circuito_codificador_param
// PURPOSE
//  Parametrised, registered successor of the 7-input one-hot encoder.
//  - Encodes an N_IN-bit input vector into a W_OUT-bit binary code.
//  - Adds a valid/ready handshake on both sides, a DEPTH-entry output FIFO and two modes:
//    strict one-hot or priority.
//  - Flags illegal (multi-hot) words and counts them; sits between input sampling logic
//    and the display/decoder stage.
// PARAMETERS
//  N_IN       7                    number of input lines (>=2)
//  W_OUT      $clog2(N_IN+1)       code width; must satisfy 2**W_OUT > N_IN
//  DEPTH      2                    output FIFO entries (power of 2, >=2)
//  MODE       0                    0 = strict one-hot; 1 = priority (highest index wins)
//  ERR_CNT_W  8                    width of saturating illegal-word counter
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_vec     in   N_IN       input lines; bit i active -> code i+1
//  in_valid   in   1          in_vec valid this cycle
//  in_ready   out  1          block accepts a word this cycle
//  out_code   out  W_OUT      encoded value at FIFO head
//  out_multi  out  1          head word had more than one bit set
//  out_valid  out  1          FIFO head valid
//  out_ready  in   1          consumer takes head this cycle
//  err_clr    in   1          synchronous clear of err_cnt
//  err_cnt    out  ERR_CNT_W  count of accepted multi-hot words, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async)
//  - FIFO empty; out_valid=0, out_code=0, out_multi=0, err_cnt=0.
//  - in_ready=1 from the first edge after deassertion.
//  Encoding (combinational, captured on accept)
//  - Accept when in_valid&&in_ready at a rising edge.
//  - All-zero -> code 0, multi=0.
//  - Exactly one bit i -> code i+1, multi=0.
//  - >1 bit, MODE=0 -> code 0, multi=1.
//  - >1 bit, MODE=1 -> code = (highest set index)+1, multi=1.
//  Latency and handshake
//  - Word accepted at edge k appears at the head (if FIFO empty) with out_valid=1 after
//    edge k: 1-cycle latency.
//  - Pop when out_valid&&out_ready. Words leave in acceptance order.
//  - in_ready = !full. There is no combinational path from out_ready to in_ready.
//  - When full, no push even if a pop occurs in the same cycle.
//  - Push+pop in the same cycle when neither full nor empty: occupancy unchanged.
//  - Push into empty with out_ready=1: the word is not bypassed; it is popped on a later cycle.
//  - out_code/out_multi are stable while out_valid=1 and out_ready=0.
//  - When out_valid=0, out_code and out_multi hold 0.
//  Pointers
//  - log2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
//  - Full/empty come from an occupancy counter 0..DEPTH.
//  Error counter
//  - +1 per accepted word with multi=1; saturates at 2**ERR_CNT_W-1.
//  - err_clr has priority over a same-cycle increment (result 0).
//  Reset mid-operation
//  - Asserting rst_n=0 immediately empties the FIFO and zeroes all outputs.
//  - Words in flight are discarded.
// TESTING
//  1. Reset, then 7 single-hot words 0000001..1000000, out_ready=1 -> codes 1..7 in order,
//     multi=0, err_cnt=0.
//  2. MODE=0, in_vec=0010100 -> out_code=0, out_multi=1, err_cnt=1.
//     MODE=1 with the same word -> out_code=5, out_multi=1.
//  3. out_ready=0, push 3 words (DEPTH=2) -> in_ready=0 after the 2nd accept; 3rd held off.
//     Release out_ready -> codes emerge in order, none lost or duplicated.
//  4. Hold FIFO at occupancy 1 with continuous push+pop for 20 cycles -> pointers wrap,
//     output sequence equals input sequence shifted by 1.
//  5. ERR_CNT_W=2, push 5 multi-hot words -> err_cnt=3 (saturated).
//     err_clr together with a multi-hot accept -> err_cnt=0.
//  6. Assert rst_n=0 mid-cycle with 2 entries queued -> out_valid=0 and err_cnt=0
//     immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/circuito_codificador_param.sv
// Parametrised one-hot / priority encoder with valid/ready handshakes,
// a small output FIFO and a saturating counter of accepted multi-hot words.
module circuito_codificador_param #(
  parameter int N_IN      = 7,
  parameter int W_OUT     = $clog2(N_IN + 1),
  parameter int DEPTH     = 2,
  parameter int MODE      = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W_OUT-1:0]     out_code,
  output logic                 out_multi,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Pointer width; occupancy counter needs one extra state to tell full from empty.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W_OUT-1:0]     enc_code;
  logic                 enc_multi;
  logic [W_OUT-1:0]     hi_code;
  logic                 seen_one;

  logic [W_OUT:0]       mem [DEPTH];
  logic [W_OUT:0]       head_word;
  logic [PW-1:0]        rd_ptr_reg;
  logic [PW-1:0]        wr_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 run_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // Scan the input lines: track the highest active line and whether more than one is set.
  always_comb begin
    hi_code   = '0;
    seen_one  = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_vec[i]) begin
        hi_code = W_OUT'(i + 1);
        if (seen_one) begin
          enc_multi = 1'b1;
        end
        seen_one = 1'b1;
      end
    end
    if (enc_multi && (MODE == 0)) begin
      enc_code = '0;
    end else begin
      enc_code = hi_code;
    end
  end

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  // in_ready depends only on registered state, so out_ready never reaches it.
  assign in_ready  = run_reg && !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head word is forced to zero whenever the FIFO is empty.
  assign head_word = mem[rd_ptr_reg];
  assign out_code  = out_valid ? head_word[W_OUT-1:0] : '0;
  assign out_multi = out_valid ? head_word[W_OUT] : 1'b0;
  assign err_cnt   = err_cnt_reg;

  // FIFO storage: no reset needed, contents are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {enc_multi, enc_code};
    end
  end

  // FIFO pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Saturating count of accepted multi-hot words; a clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= '0;
    end else if (push && enc_multi && (err_cnt_reg != {ERR_CNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_circuito_codificador_param.sv
// Scoreboard bench: three encoder instances (strict, priority, 2-bit error
// counter) share one stimulus stream; a negedge monitor checks each against
// a per-instance expected queue built from the encoding rules.
module tb_circuito_codificador_param;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] in_vec = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic       rdy0, rdy1, rdy2;
  logic       vld0, vld1, vld2;
  logic [2:0] code0, code1, code2;
  logic       multi0, multi1, multi2;
  logic [7:0] err0, err1;
  logic [1:0] err2;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int q0[$];
  int q1[$];
  int q2[$];
  int err_m[3];

  always #5 clk = ~clk;

  circuito_codificador_param #(.N_IN(7), .DEPTH(D), .MODE(0), .ERR_CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(rdy0),
    .out_code(code0), .out_multi(multi0), .out_valid(vld0), .out_ready(out_ready),
    .err_clr(err_clr), .err_cnt(err0));

  circuito_codificador_param #(.N_IN(7), .DEPTH(D), .MODE(1), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(rdy1),
    .out_code(code1), .out_multi(multi1), .out_valid(vld1), .out_ready(out_ready),
    .err_clr(err_clr), .err_cnt(err1));

  circuito_codificador_param #(.N_IN(7), .DEPTH(D), .MODE(0), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(rdy2),
    .out_code(code2), .out_multi(multi2), .out_valid(vld2), .out_ready(out_ready),
    .err_clr(err_clr), .err_cnt(err2));

  // Reference encoding: result = 16*multi + code.
  function automatic int expect_word(input logic [6:0] v, input int mode);
    int ones;
    int x;
    ones = $countones(v);
    x = int'(v);
    if (ones == 0) return 0;
    if (ones == 1) return $clog2(x) + 1;
    return 16 + ((mode == 1) ? $clog2(x + 1) : 0);
  endfunction

  function automatic int q_size(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int q_front(input int id);
    case (id)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void q_pop(input int id);
    int dummy;
    case (id)
      0: dummy = q0.pop_front();
      1: dummy = q1.pop_front();
      default: dummy = q2.pop_front();
    endcase
  endfunction

  function automatic void q_push(input int id, input int val);
    case (id)
      0: q0.push_back(val);
      1: q1.push_back(val);
      default: q2.push_back(val);
    endcase
  endfunction

  function automatic void q_clear(input int id);
    case (id)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic mon(input int id, input logic rdy, input logic vld, input logic [2:0] code,
                     input logic multi, input int errc, input int mode, input int errmax);
    int exp_rdy;
    int w;
    int act;
    act = int'(multi) * 16 + int'(code);
    if (!rst_n) begin
      check($sformatf("dut%0d valid_in_reset", id), int'(vld), 0);
      check($sformatf("dut%0d word_in_reset", id), act, 0);
      check($sformatf("dut%0d err_in_reset", id), errc, 0);
      q_clear(id);
      err_m[id] = 0;
      return;
    end
    exp_rdy = ((edges > 0) && (q_size(id) < D)) ? 1 : 0;
    check($sformatf("dut%0d in_ready", id), int'(rdy), exp_rdy);
    check($sformatf("dut%0d err_cnt", id), errc, err_m[id]);
    if (q_size(id) > 0) begin
      check($sformatf("dut%0d out_valid", id), int'(vld), 1);
      check($sformatf("dut%0d head_word", id), act, q_front(id));
      if (out_ready) begin
        $display("dut%0d pop code=%0d multi=%0d exp=%0d", id, code, multi, q_front(id));
        q_pop(id);
      end
    end else begin
      check($sformatf("dut%0d out_valid_idle", id), int'(vld), 0);
      check($sformatf("dut%0d word_idle", id), act, 0);
    end
    w = expect_word(in_vec, mode);
    if (in_valid && (exp_rdy == 1)) q_push(id, w);
    if (err_clr) err_m[id] = 0;
    else if (in_valid && (exp_rdy == 1) && (w >= 16) && (err_m[id] < errmax)) err_m[id]++;
  endtask

  // Count edges since reset release; in_ready is only expected after the first one.
  always @(posedge clk) begin
    if (!rst_n) edges = 0;
    else edges++;
  end

  // Monitor: compare every instance against its scoreboard on the falling edge.
  always @(negedge clk) begin
    mon(0, rdy0, vld0, code0, multi0, int'(err0), 0, 255);
    mon(1, rdy1, vld1, code1, multi1, int'(err1), 1, 255);
    mon(2, rdy2, vld2, code2, multi2, int'(err2), 0, 3);
  end

  task automatic send(input logic [6:0] v);
    bit ok;
    ok = 1'b0;
    in_vec = v;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy0 && rst_n) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got not accepted, expected accept of %b", v);
    end
  endtask

  function automatic logic [6:0] rand_multi();
    logic [6:0] v;
    v = 7'($urandom);
    if ($countones(v) < 2) v = v | 7'b0000011;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-hot walk, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(7'(1 << i));
    repeat (3) @(posedge clk);
    #1;

    // Multi-hot word: strict gives 0, priority gives 5.
    send(7'b0010100);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: third word held off until the consumer resumes.
    out_ready = 1'b0;
    fork
      begin
        send(7'b0000100);
        send(7'b0100000);
        send(7'b0000001);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Occupancy held at 1 with push+pop every cycle.
    out_ready = 1'b0;
    send(7'(1 << ($urandom % 7)));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(7'(1 << ($urandom % 7)));
    repeat (3) @(posedge clk);
    #1;

    // Saturation of the narrow counter, then clear against a same-cycle increment.
    for (int i = 0; i < 5; i++) send(rand_multi());
    err_clr = 1'b1;
    send(7'b1100000);
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with two entries queued.
    out_ready = 1'b0;
    send(rand_multi());
    send(rand_multi());
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst vld0", int'(vld0), 0);
    check("async_rst vld1", int'(vld1), 0);
    check("async_rst vld2", int'(vld2), 0);
    check("async_rst err0", int'(err0), 0);
    check("async_rst err2", int'(err2), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      case ($urandom % 3)
        0: in_vec = 7'(1 << ($urandom % 7));
        1: in_vec = 7'($urandom);
        default: in_vec = '0;
      endcase
      out_ready = ($urandom % 3) != 0;
      err_clr = ($urandom % 25) == 0;
      @(posedge clk);
      #1;
    end

    in_valid = 1'b0;
    err_clr = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
